// File: rtl/m_7seg_scan_if.sv
// Display bus between the board logic and the 7-segment scanner.
// master: drives the value, load strobe, mode, blanking and decimal points; sees busy and pins.
// slave : the scanner; captures inputs and drives busy, segment, decimal-point and anode pins.
interface m_7seg_scan_if #(
    parameter int DIGITS = 8,
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] w_din;
    logic              w_load;
    logic              w_mode;
    logic              w_blank_lz;
    logic [DIGITS-1:0] w_dp;
    logic              w_busy;
    logic [6:0]        r_sg;
    logic              r_dp;
    logic [DIGITS-1:0] r_an;

    modport master (
        output w_din, w_load, w_mode, w_blank_lz, w_dp,
        input  w_busy, r_sg, r_dp, r_an
    );

    modport slave (
        input  w_din, w_load, w_mode, w_blank_lz, w_dp,
        output w_busy, r_sg, r_dp, r_an
    );
endinterface

// File: rtl/m_7seg_scan.sv
// Multiplexed common-anode 7-segment controller, hex or unsigned decimal (serial double-dabble).
// Latency: hex value shown from the next edge; decimal after DATA_W+1 edges; pins registered.
// Backpressure: w_busy is high during conversion; any w_load seen while busy is dropped.
// Ports: w_clk/w_rst_n plain; bus (slave) carries w_din, w_load, w_mode, w_blank_lz, w_dp in,
//        w_busy, r_sg (active-low {a..g}), r_dp (active-low), r_an (active-low one-hot) out.
module m_7seg_scan #(
    parameter int DIGITS = 8,
    parameter int DATA_W = 32,
    parameter int DELAY  = 100000
) (
    input  logic          w_clk,
    input  logic          w_rst_n,
    m_7seg_scan_if.slave  bus
);
    localparam int NW = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int BW = $clog2(DATA_W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // scan side
    logic [CW-1:0]     scan_cnt;
    logic [IW-1:0]     dig_idx;     // digit that becomes active at the next wrap
    logic [IW-1:0]     act_idx;     // digit currently driven on the anodes
    logic [IW-1:0]     act_idx_n;
    logic              scan_on;     // anodes stay dark until the first period has elapsed
    logic              scan_wrap;

    // displayed value
    logic [NW-1:0]     disp;
    logic              disp_ovf;

    // converter
    logic [1:0]        state;
    logic [DATA_W-1:0] bin_sr;
    logic [NW-1:0]     bcd_sr;
    logic [NW-1:0]     bcd_adj;
    logic [BW-1:0]     bit_cnt;
    logic              cnv_ovf;
    logic              load_ok;

    logic [DIGITS-1:0] lz;
    logic [3:0]        nib_n;
    logic [6:0]        seg_n;
    logic              dp_n;

    // active-high {a,b,c,d,e,f,g}
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0:    return 7'b1111110;
            4'h1:    return 7'b0110000;
            4'h2:    return 7'b1101101;
            4'h3:    return 7'b1111001;
            4'h4:    return 7'b0110011;
            4'h5:    return 7'b1011011;
            4'h6:    return 7'b1011111;
            4'h7:    return 7'b1110000;
            4'h8:    return 7'b1111111;
            4'h9:    return 7'b1111011;
            4'hA:    return 7'b1110111;
            4'hB:    return 7'b0011111;
            4'hC:    return 7'b1001110;
            4'hD:    return 7'b0111101;
            4'hE:    return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    assign scan_wrap   = (scan_cnt == CW'(DELAY - 1));
    assign bus.w_busy  = (state != S_IDLE);
    assign load_ok     = bus.w_load && (state == S_IDLE);

    // add-3 correction applied to every BCD digit before each shift
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bcd_adj[4*i +: 4] = (bcd_sr[4*i +: 4] >= 4'd5) ? bcd_sr[4*i +: 4] + 4'd3
                                                            : bcd_sr[4*i +: 4];
        end
    end

    // lz[i]: digits i..DIGITS-1 are all zero
    always_comb begin
        lz = '0;
        lz[DIGITS-1] = (disp[NW-1 -: 4] == 4'd0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            lz[i] = lz[i+1] && (disp[4*i +: 4] == 4'd0);
        end
    end

    // Pins are computed from the digit that will be active after this edge, so anode,
    // segments and decimal point always change together.
    always_comb begin
        act_idx_n = scan_wrap ? dig_idx : act_idx;
        nib_n     = disp[{act_idx_n, 2'b00} +: 4];
        if (disp_ovf) begin
            seg_n = 7'b0000001;
        end else if (bus.w_blank_lz && (act_idx_n != '0) && lz[act_idx_n]) begin
            seg_n = 7'b0000000;
        end else begin
            seg_n = seg7(nib_n);
        end
        dp_n = !disp_ovf && bus.w_dp[act_idx_n];
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
            act_idx  <= '0;
            scan_on  <= 1'b0;
            bus.r_an <= '1;
            bus.r_sg <= 7'h7f;
            bus.r_dp <= 1'b1;
        end else begin
            act_idx <= act_idx_n;
            if (scan_wrap) begin
                scan_cnt <= '0;
                scan_on  <= 1'b1;
                dig_idx  <= (dig_idx == IW'(DIGITS - 1)) ? '0 : dig_idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            if (scan_on || scan_wrap) begin
                bus.r_an <= ~(DIGITS'(1) << act_idx_n);
                bus.r_sg <= ~seg_n;
                bus.r_dp <= ~dp_n;
            end
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state    <= S_IDLE;
            bin_sr   <= '0;
            bcd_sr   <= '0;
            bit_cnt  <= '0;
            cnv_ovf  <= 1'b0;
            disp     <= '0;
            disp_ovf <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_ok) begin
                        if (bus.w_mode) begin
                            bin_sr  <= bus.w_din;
                            bcd_sr  <= '0;
                            bit_cnt <= '0;
                            cnv_ovf <= 1'b0;
                            state   <= S_SHIFT;
                        end else begin
                            // zero-extends or truncates to the visible nibbles
                            disp     <= NW'(bus.w_din);
                            disp_ovf <= 1'b0;
                        end
                    end
                end
                S_SHIFT: begin
                    bcd_sr  <= {bcd_adj[NW-2:0], bin_sr[DATA_W-1]};
                    bin_sr  <= bin_sr << 1;
                    // a carry out of the top digit means the value needs more digits
                    if (bcd_adj[NW-1]) begin
                        cnv_ovf <= 1'b1;
                    end
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == BW'(DATA_W - 1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    disp     <= bcd_sr;
                    disp_ovf <= cnv_ovf;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_m_7seg_scan.sv
// Self-checking bench for m_7seg_scan (4 digits, 16-bit data, 4-cycle digit period).
// Expected pins come from a digit-arithmetic model of the displayed value.
module tb_m_7seg_scan;
    localparam int DIGITS = 4;
    localparam int DATA_W = 16;
    localparam int DELAY  = 4;

    logic w_clk = 1'b0;
    logic w_rst_n;
    always #5 w_clk = ~w_clk;

    m_7seg_scan_if #(.DIGITS(DIGITS), .DATA_W(DATA_W)) bus ();

    m_7seg_scan #(.DIGITS(DIGITS), .DATA_W(DATA_W), .DELAY(DELAY)) dut (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .bus     (bus)
    );

    int          vecs = 0;
    int          errs = 0;
    int unsigned cur_val = 0;
    bit          cur_dec = 1'b0;

    // expected active-low segments for digit i of value v
    function automatic logic [6:0] model_sg(input int unsigned v, input bit dec,
                                            input bit blz, input int i);
        int unsigned base;
        int unsigned p;
        int unsigned d;
        logic [6:0]  on;
        base = dec ? 10 : 16;
        p    = 1;
        if (dec && v >= 10000) return 7'b1111110;
        for (int k = 0; k < i; k++) p = p * base;
        if (blz && i > 0 && v < p) return 7'h7f;
        d = (v / p) % base;
        case (d)
            0: on = 7'b1111110;  1: on = 7'b0110000;  2: on = 7'b1101101;  3: on = 7'b1111001;
            4: on = 7'b0110011;  5: on = 7'b1011011;  6: on = 7'b1011111;  7: on = 7'b1110000;
            8: on = 7'b1111111;  9: on = 7'b1111011; 10: on = 7'b1110111; 11: on = 7'b0011111;
           12: on = 7'b1001110; 13: on = 7'b0111101; 14: on = 7'b1001111; default: on = 7'b1000111;
        endcase
        return ~on;
    endfunction

    function automatic logic model_dp(input int unsigned v, input bit dec,
                                      input logic [3:0] dp, input int i);
        if (dec && v >= 10000) return 1'b1;
        return ~dp[i];
    endfunction

    task automatic wait_digit(input int i, output bit ok);
        logic [3:0] onehot;
        onehot = 4'b0001 << i;
        ok = 1'b0;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge w_clk);
            if (bus.r_an === ~onehot) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge w_clk);
            if (bus.w_busy === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic do_load(input int unsigned v, input bit dec);
        @(negedge w_clk);
        bus.w_din  = v[15:0];
        bus.w_mode = dec;
        bus.w_load = 1'b1;
        @(negedge w_clk);
        bus.w_load = 1'b0;
    endtask

    task automatic test_reset;
        logic [3:0] exp_an;
        logic [3:0] onehot;
        w_rst_n        = 1'b0;
        bus.w_din      = '0;
        bus.w_load     = 1'b0;
        bus.w_mode     = 1'b0;
        bus.w_blank_lz = 1'b0;
        bus.w_dp       = '0;
        #22;
        vecs++; if (bus.r_an !== 4'b1111) begin errs++; $display("FAIL reset_an: got %b expected 1111", bus.r_an); end
        vecs++; if (bus.r_sg !== 7'h7f) begin errs++; $display("FAIL reset_sg: got %b expected 1111111", bus.r_sg); end
        vecs++; if (bus.r_dp !== 1'b1) begin errs++; $display("FAIL reset_dp: got %b expected 1", bus.r_dp); end
        vecs++; if (bus.w_busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", bus.w_busy); end
        @(negedge w_clk);
        w_rst_n = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(posedge w_clk); #1;
            onehot = 4'b0001 << (((c - 4) / 4) % 4);
            exp_an = (c < 4) ? 4'b1111 : ~onehot;
            vecs++;
            if (bus.r_an !== exp_an) begin
                errs++; $display("FAIL scan_seq c=%0d: got %b expected %b", c, bus.r_an, exp_an);
            end
        end
        cur_val = 0; cur_dec = 1'b0;
    endtask

    task automatic test_hex;
        bit ok;
        bus.w_blank_lz = 1'b0;
        bus.w_dp       = 4'b0000;
        do_load(16'h1A3F, 1'b0);
        vecs++; if (bus.w_busy !== 1'b0) begin errs++; $display("FAIL hex_busy: got %b expected 0", bus.w_busy); end
        cur_val = 16'h1A3F; cur_dec = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            wait_digit(i, ok);
            vecs++;
            if (!ok) begin errs++; $display("FAIL hex_anode d%0d: anode never active", i); end
            else if (bus.r_sg !== model_sg(cur_val, cur_dec, 1'b0, i)) begin
                errs++; $display("FAIL hex_sg d%0d: got %b expected %b", i, bus.r_sg, model_sg(cur_val, cur_dec, 1'b0, i));
            end
            if (ok && i == 0) begin
                vecs++;
                if (bus.r_sg !== 7'b0111000) begin errs++; $display("FAIL hex_F_code: got %b expected 0111000", bus.r_sg); end
            end
        end
    endtask

    task automatic test_decimal;
        int          busy_cnt;
        int unsigned old_val;
        bit          old_dec;
        bit          ok;
        logic [3:0]  onehot;
        old_val = cur_val; old_dec = cur_dec;
        @(negedge w_clk);
        bus.w_din = 16'd1234; bus.w_mode = 1'b1; bus.w_load = 1'b1;
        @(posedge w_clk); #1;
        bus.w_load = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.w_busy !== 1'b1) break;
            busy_cnt++;
            for (int d = 0; d < DIGITS; d++) begin
                onehot = 4'b0001 << d;
                if (bus.r_an === ~onehot) begin
                    vecs++;
                    if (bus.r_sg !== model_sg(old_val, old_dec, 1'b0, d)) begin
                        errs++; $display("FAIL dec_old_value d%0d: got %b expected %b", d, bus.r_sg, model_sg(old_val, old_dec, 1'b0, d));
                    end
                end
            end
            @(posedge w_clk); #1;
        end
        vecs++;
        if (busy_cnt != 17) begin errs++; $display("FAIL dec_busy_len: got %0d expected 17", busy_cnt); end
        cur_val = 1234; cur_dec = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            wait_digit(i, ok);
            vecs++;
            if (!ok) begin errs++; $display("FAIL dec_anode d%0d: anode never active", i); end
            else if (bus.r_sg !== model_sg(cur_val, cur_dec, 1'b0, i)) begin
                errs++; $display("FAIL dec_sg d%0d: got %b expected %b", i, bus.r_sg, model_sg(cur_val, cur_dec, 1'b0, i));
            end
        end
    endtask

    task automatic test_overflow;
        bit ok;
        bus.w_blank_lz = 1'b1;
        bus.w_dp       = 4'b1111;
        do_load(16'd12345, 1'b1);
        wait_idle(ok);
        vecs++; if (!ok) begin errs++; $display("FAIL ovf_idle: busy never dropped"); end
        cur_val = 12345; cur_dec = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            wait_digit(i, ok);
            vecs++;
            if (!ok) begin errs++; $display("FAIL ovf_anode d%0d: anode never active", i); end
            else if (bus.r_sg !== model_sg(cur_val, cur_dec, 1'b1, i) || bus.r_dp !== model_dp(cur_val, cur_dec, 4'b1111, i)) begin
                errs++; $display("FAIL ovf_dash d%0d: got sg=%b dp=%b expected sg=%b dp=%b", i, bus.r_sg, bus.r_dp,
                                 model_sg(cur_val, cur_dec, 1'b1, i), model_dp(cur_val, cur_dec, 4'b1111, i));
            end
        end
    endtask

    task automatic test_blanking;
        bit         ok;
        bit         blz;
        logic [3:0] dp;
        bus.w_blank_lz = 1'b0;
        bus.w_dp       = 4'b0000;
        do_load(16'd7, 1'b1);
        wait_idle(ok);
        vecs++; if (!ok) begin errs++; $display("FAIL blank_idle: busy never dropped"); end
        cur_val = 7; cur_dec = 1'b1;
        for (int ph = 0; ph < 3; ph++) begin
            blz = (ph == 0);
            dp  = (ph == 2) ? 4'b0010 : 4'b0000;
            @(negedge w_clk);
            bus.w_blank_lz = blz;
            bus.w_dp       = dp;
            for (int i = 0; i < DIGITS; i++) begin
                wait_digit(i, ok);
                vecs++;
                if (!ok) begin errs++; $display("FAIL blank_anode ph%0d d%0d: anode never active", ph, i); end
                else if (bus.r_sg !== model_sg(cur_val, cur_dec, blz, i) || bus.r_dp !== model_dp(cur_val, cur_dec, dp, i)) begin
                    errs++; $display("FAIL blank ph%0d d%0d: got sg=%b dp=%b expected sg=%b dp=%b", ph, i, bus.r_sg, bus.r_dp,
                                     model_sg(cur_val, cur_dec, blz, i), model_dp(cur_val, cur_dec, dp, i));
                end
            end
        end
        bus.w_dp = 4'b0000;
    endtask

    task automatic test_interference;
        bit ok;
        bus.w_blank_lz = 1'b0;
        bus.w_dp       = 4'b0000;
        do_load(16'd99, 1'b1);
        repeat (2) @(negedge w_clk);
        vecs++; if (bus.w_busy !== 1'b1) begin errs++; $display("FAIL intf_busy: got %b expected 1", bus.w_busy); end
        do_load(16'h5555, 1'b0);
        wait_idle(ok);
        vecs++; if (!ok) begin errs++; $display("FAIL intf_idle: busy never dropped"); end
        cur_val = 99; cur_dec = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            wait_digit(i, ok);
            vecs++;
            if (!ok) begin errs++; $display("FAIL intf_anode d%0d: anode never active", i); end
            else if (bus.r_sg !== model_sg(cur_val, cur_dec, 1'b0, i)) begin
                errs++; $display("FAIL intf_sg d%0d: got %b expected %b", i, bus.r_sg, model_sg(cur_val, cur_dec, 1'b0, i));
            end
        end
        // reset in the middle of a conversion
        do_load(16'd4321, 1'b1);
        repeat (5) @(negedge w_clk);
        #2 w_rst_n = 1'b0;
        #1;
        vecs++;
        if (bus.r_an !== 4'b1111 || bus.r_sg !== 7'h7f || bus.r_dp !== 1'b1 || bus.w_busy !== 1'b0) begin
            errs++; $display("FAIL midreset: got an=%b sg=%b dp=%b busy=%b expected 1111 1111111 1 0",
                             bus.r_an, bus.r_sg, bus.r_dp, bus.w_busy);
        end
        @(negedge w_clk);
        w_rst_n = 1'b1;
        cur_val = 0; cur_dec = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            wait_digit(i, ok);
            vecs++;
            if (!ok) begin errs++; $display("FAIL postreset_anode d%0d: anode never active", i); end
            else if (bus.r_sg !== model_sg(cur_val, cur_dec, 1'b0, i) || bus.w_busy !== 1'b0) begin
                errs++; $display("FAIL postreset d%0d: got sg=%b busy=%b expected sg=%b busy=0", i, bus.r_sg, bus.w_busy,
                                 model_sg(cur_val, cur_dec, 1'b0, i));
            end
        end
    endtask

    task automatic test_random;
        bit          ok;
        int unsigned v;
        bit          dec;
        bit          blz;
        logic [3:0]  dp;
        for (int n = 0; n < 12; n++) begin
            v   = $urandom_range(0, 65535);
            if ($urandom_range(0, 2) == 0) v = $urandom_range(0, 300);
            dec = 1'($urandom_range(0, 1));
            blz = 1'($urandom_range(0, 1));
            dp  = 4'($urandom_range(0, 15));
            bus.w_blank_lz = blz;
            bus.w_dp       = dp;
            do_load(v, dec);
            wait_idle(ok);
            vecs++; if (!ok) begin errs++; $display("FAIL rnd_idle n%0d: busy never dropped", n); end
            cur_val = v; cur_dec = dec;
            for (int i = 0; i < DIGITS; i++) begin
                wait_digit(i, ok);
                vecs++;
                if (!ok) begin errs++; $display("FAIL rnd_anode n%0d d%0d: anode never active", n, i); end
                else if (bus.r_sg !== model_sg(v, dec, blz, i) || bus.r_dp !== model_dp(v, dec, dp, i)) begin
                    errs++; $display("FAIL rnd n%0d v=%0d dec=%0d blz=%0d dp=%b d%0d: got sg=%b dp=%b expected sg=%b dp=%b",
                                     n, v, dec, blz, dp, i, bus.r_sg, bus.r_dp, model_sg(v, dec, blz, i), model_dp(v, dec, dp, i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_hex();
        test_decimal();
        test_overflow();
        test_blanking();
        test_interference();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
